nibble_encoder_display: RTL and testbench
=========================================

Name: nibble_encoder_display

Overview:
- Registered 4-bit binary-to-Gray encoder with four 1-bit seven-segment digit drivers, one per output bit.
- Captures the input nibble on a `ready` strobe and holds the encoded result until the next strobe.
- Sits between switch/key inputs and a four-digit LED panel. Each digit shows "0" or "1" for its code bit.

Parameters:
- SEG_ACTIVE_LOW, 0, 0 = segment lit by logic 1; 1 = every segment output is inverted (common-anode panels).

Ports:
- clock  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- ready  input  1  capture strobe, sampled on rising clock edge
- a  input  1  input nibble bit 3 (MSB)
- b  input  1  input nibble bit 2
- c  input  1  input nibble bit 1
- d  input  1  input nibble bit 0 (LSB)
- s3  output  1  encoded bit 3
- s2  output  1  encoded bit 2
- s1  output  1  encoded bit 1
- s0  output  1  encoded bit 0
- valid  output  1  high once at least one capture has occurred since reset
- display3  output  7  segments for s3, order {a,b,c,d,e,f,g}, bit 6 = segment a
- display2  output  7  segments for s2
- display1  output  7  segments for s1
- display0  output  7  segments for s0
- display_hex  output  7  hex glyph of the encoded nibble (present only with HEX_DISPLAY_EN)

Behaviour:
- Reset (reset low, asynchronous):
  - s3..s0 = 0, valid = 0.
  - display3..0 show glyph "0".
  - Release is synchronised to the clock by the implementation.
- Capture: on a rising edge with reset high and ready = 1:
  - s3 <= a
  - s2 <= a ^ b
  - s1 <= b ^ c
  - s0 <= c ^ d
  - valid <= 1
- Hold: ready = 0 keeps s3..s0 and valid unchanged; input changes are ignored.
- Latency: one clock edge from ready sampled high to new s-values. Display outputs follow combinationally in the same cycle.
- Back-to-back strobes: ready held high for N cycles captures every cycle, so the last sampled input wins.
- No clock gating or busy state. A single register stage, with no FSM beyond valid.
- Digit decoder (pure combinational, one instance per bit):
  - bit 0 -> 7'b1111110 (glyph "0")
  - bit 1 -> 7'b0110000 (glyph "1")
  - Unknown/X input must not occur after reset.
- SEG_ACTIVE_LOW = 1 inverts all seven bits of every display output, including display_hex.
- Reset asserted mid-operation: immediately clears registers and displays regardless of ready or clock.

Optional Feature:
- Macro: HEX_DISPLAY_EN.
- When defined:
  - Port display_hex exists and shows the encoded nibble {s3,s2,s1,s0} as a hex glyph.
  - Codes 0..F: 7E,30,6D,79,33,5B,5F,70,7F,7B,77,1F,4E,3D,4F,47.
  - Reset value 7E (inverted if SEG_ACTIVE_LOW).
- When undefined: port and decoder are absent; all other behaviour is identical.

Test Plan:
- Reset with reset=0, a..d=1111, ready=1 toggling -> s=0000, valid=0, display3..0=1111110 throughout.
- Release reset, apply 1011, pulse ready for one edge -> after that edge:
  - s=1110, valid=1
  - display3..1=0110000, display0=1111110
  - display_hex=4F
- After capturing 1011, change input to 0100 with ready=0 for 3 cycles -> s stays 1110.
- Sweep 0000..1111, one ready pulse each, then check one cycle later:
  - s equals Gray code (e.g. 0111->0100, 1000->1100, 1111->1000).
  - Each display matches its bit.
- Capture 1111 (s=1000), then assert reset between clock edges -> s=0000 and valid=0 immediately, without waiting for a clock edge.
- SEG_ACTIVE_LOW=1, capture 0001 (s=0001) -> display0=1001111, display3..1=0000001.

Source files
------------

// File: rtl/nibble_encoder_display.sv
// Registered 4-bit binary-to-Gray encoder driving four 1-bit seven-segment digits.
// Optional hex glyph of the encoded nibble is enabled by defining HEX_DISPLAY_EN.
module nibble_encoder_display #(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ready,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output logic       s3,
    output logic       s2,
    output logic       s1,
    output logic       s0,
    output logic       valid,
    output logic [6:0] display3,
    output logic [6:0] display2,
    output logic [6:0] display1,
`ifdef HEX_DISPLAY_EN
    output logic [6:0] display0,
    output logic [6:0] display_hex
`else
    output logic [6:0] display0
`endif
);

    logic [1:0] rst_sync_r;
    logic       rst_n_s;
    logic [3:0] code_r;
    logic       valid_r;
    logic [3:0] gray_s;
    logic [6:0] seg3_s;
    logic [6:0] seg2_s;
    logic [6:0] seg1_s;
    logic [6:0] seg0_s;

    function automatic logic [3:0] gray_encode(input logic [3:0] bin);
        return bin ^ {1'b0, bin[3:1]};
    endfunction

    function automatic logic [6:0] seg_polarity(input logic [6:0] seg);
        logic [6:0] out_v;
        if (SEG_ACTIVE_LOW) begin
            out_v = ~seg;
        end else begin
            out_v = seg;
        end
        return out_v;
    endfunction

    function automatic logic [6:0] seg_digit(input logic bit_v);
        logic [6:0] seg_v;
        case (bit_v)
            1'b0:    seg_v = 7'b1111110;
            1'b1:    seg_v = 7'b0110000;
            default: seg_v = 7'b1111110;
        endcase
        return seg_polarity(seg_v);
    endfunction

`ifdef HEX_DISPLAY_EN
    logic [6:0] seg_hex_s;

    function automatic logic [6:0] seg_hex(input logic [3:0] nib);
        logic [6:0] seg_v;
        case (nib)
            4'h0:    seg_v = 7'h7E;
            4'h1:    seg_v = 7'h30;
            4'h2:    seg_v = 7'h6D;
            4'h3:    seg_v = 7'h79;
            4'h4:    seg_v = 7'h33;
            4'h5:    seg_v = 7'h5B;
            4'h6:    seg_v = 7'h5F;
            4'h7:    seg_v = 7'h70;
            4'h8:    seg_v = 7'h7F;
            4'h9:    seg_v = 7'h7B;
            4'hA:    seg_v = 7'h77;
            4'hB:    seg_v = 7'h1F;
            4'hC:    seg_v = 7'h4E;
            4'hD:    seg_v = 7'h3D;
            4'hE:    seg_v = 7'h4F;
            4'hF:    seg_v = 7'h47;
            default: seg_v = 7'h7E;
        endcase
        return seg_polarity(seg_v);
    endfunction
`endif

    // Reset synchroniser: asserts immediately, releases two clock edges later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];
    assign gray_s  = gray_encode({a, b, c, d});

    // Capture register: loads the Gray code on ready, otherwise holds.
    always_ff @(posedge clock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            code_r  <= 4'b0000;
            valid_r <= 1'b0;
        end else if (ready) begin
            code_r  <= gray_s;
            valid_r <= 1'b1;
        end else begin
            code_r  <= code_r;
            valid_r <= valid_r;
        end
    end

    // Digit decoders follow the registered code combinationally.
    always_comb begin
        seg3_s = seg_digit(code_r[3]);
        seg2_s = seg_digit(code_r[2]);
        seg1_s = seg_digit(code_r[1]);
        seg0_s = seg_digit(code_r[0]);
    end

`ifdef HEX_DISPLAY_EN
    // Hex glyph of the whole encoded nibble.
    always_comb begin
        seg_hex_s = seg_hex(code_r);
    end

    assign display_hex = seg_hex_s;
`endif

    assign s3       = code_r[3];
    assign s2       = code_r[2];
    assign s1       = code_r[1];
    assign s0       = code_r[0];
    assign valid    = valid_r;
    assign display3 = seg3_s;
    assign display2 = seg2_s;
    assign display1 = seg1_s;
    assign display0 = seg0_s;

endmodule

// File: tb/tb_nibble_encoder_display.sv
// Directed, table-driven bench for nibble_encoder_display (active-high and active-low builds).
// Covers HEX_DISPLAY_EN when the macro is defined for the whole compile.
module tb_nibble_encoder_display;

    logic       clock;
    logic       reset;
    logic       ready;
    logic       a, b, c, d;
    logic       s3, s2, s1, s0, valid;
    logic [6:0] display3, display2, display1, display0;
    logic       l_s3, l_s2, l_s1, l_s0, l_valid;
    logic [6:0] l_display3, l_display2, l_display1, l_display0;
`ifdef HEX_DISPLAY_EN
    logic [6:0] display_hex, l_display_hex;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [6:0] G0 = 7'b1111110;
    localparam logic [6:0] G1 = 7'b0110000;

    typedef struct {
        logic [3:0] nib;
        logic [3:0] gray;
        logic [6:0] hex;
    } vec_t;

    vec_t vecs[16];

    nibble_encoder_display #(.SEG_ACTIVE_LOW(1'b0)) u_dut (
        .clock(clock), .reset(reset), .ready(ready),
        .a(a), .b(b), .c(c), .d(d),
        .s3(s3), .s2(s2), .s1(s1), .s0(s0), .valid(valid),
        .display3(display3), .display2(display2), .display1(display1),
`ifdef HEX_DISPLAY_EN
        .display0(display0), .display_hex(display_hex)
`else
        .display0(display0)
`endif
    );

    nibble_encoder_display #(.SEG_ACTIVE_LOW(1'b1)) u_dut_al (
        .clock(clock), .reset(reset), .ready(ready),
        .a(a), .b(b), .c(c), .d(d),
        .s3(l_s3), .s2(l_s2), .s1(l_s1), .s0(l_s0), .valid(l_valid),
        .display3(l_display3), .display2(l_display2), .display1(l_display1),
`ifdef HEX_DISPLAY_EN
        .display0(l_display0), .display_hex(l_display_hex)
`else
        .display0(l_display0)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] dig(input logic v);
        return v ? G1 : G0;
    endfunction

    task automatic check_all(input string tag, input logic [3:0] exp_s, input logic exp_v,
                             input logic [6:0] exp_hex);
        check({tag, " s"}, {28'd0, s3, s2, s1, s0}, {28'd0, exp_s});
        check({tag, " valid"}, {31'd0, valid}, {31'd0, exp_v});
        check({tag, " disp"}, {4'd0, display3, display2, display1, display0},
              {4'd0, dig(exp_s[3]), dig(exp_s[2]), dig(exp_s[1]), dig(exp_s[0])});
        check({tag, " disp_al"}, {4'd0, l_display3, l_display2, l_display1, l_display0},
              {4'd0, ~dig(exp_s[3]), ~dig(exp_s[2]), ~dig(exp_s[1]), ~dig(exp_s[0])});
`ifdef HEX_DISPLAY_EN
        check({tag, " hex"}, {25'd0, display_hex}, {25'd0, exp_hex});
        check({tag, " hex_al"}, {25'd0, l_display_hex}, {25'd0, ~exp_hex});
`else
        if (exp_hex === 7'bxxxxxxx) $display("unexpected unknown glyph");
`endif
    endtask

    task automatic capture(input logic [3:0] nib);
        @(negedge clock);
        {a, b, c, d} = nib;
        ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{4'h0, 4'h0, 7'h7E};
        vecs[1]  = '{4'h1, 4'h1, 7'h30};
        vecs[2]  = '{4'h2, 4'h3, 7'h79};
        vecs[3]  = '{4'h3, 4'h2, 7'h6D};
        vecs[4]  = '{4'h4, 4'h6, 7'h5F};
        vecs[5]  = '{4'h5, 4'h7, 7'h70};
        vecs[6]  = '{4'h6, 4'h5, 7'h5B};
        vecs[7]  = '{4'h7, 4'h4, 7'h33};
        vecs[8]  = '{4'h8, 4'hC, 7'h4E};
        vecs[9]  = '{4'h9, 4'hD, 7'h3D};
        vecs[10] = '{4'hA, 4'hF, 7'h47};
        vecs[11] = '{4'hB, 4'hE, 7'h4F};
        vecs[12] = '{4'hC, 4'hA, 7'h77};
        vecs[13] = '{4'hD, 4'hB, 7'h1F};
        vecs[14] = '{4'hE, 4'h9, 7'h7B};
        vecs[15] = '{4'hF, 4'h8, 7'h7F};

        // Reset held with inputs all ones and ready toggling.
        reset = 1'b0;
        {a, b, c, d} = 4'b1111;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_all("reset", 4'b0000, 1'b0, 7'h7E);
            ready = ~ready;
        end

        // Release and let the synchroniser settle before the first strobe.
        ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_all("post_release", 4'b0000, 1'b0, 7'h7E);

        capture(4'b1011);
        check_all("cap_1011", 4'b1110, 1'b1, 7'h4F);

        // Input changes without a strobe are ignored.
        {a, b, c, d} = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_all("hold", 4'b1110, 1'b1, 7'h4F);
        end

        for (int i = 0; i < 16; i++) begin
            capture(vecs[i].nib);
            check_all($sformatf("sweep_%0h", vecs[i].nib), vecs[i].gray, 1'b1, vecs[i].hex);
        end

        // Active-low panel showing code 0001.
        capture(4'b0001);
        check("al_disp0", {25'd0, l_display0}, {25'd0, 7'b1001111});
        check("al_disp3_1", {11'd0, l_display3, l_display2, l_display1},
              {11'd0, 7'b0000001, 7'b0000001, 7'b0000001});
        check("al_s", {28'd0, l_s3, l_s2, l_s1, l_s0}, 32'd1);

        // Back-to-back strobes: last sampled input wins.
        @(negedge clock);
        {a, b, c, d} = 4'b0010;
        ready = 1'b1;
        @(negedge clock);
        check_all("b2b_first", 4'b0011, 1'b1, 7'h79);
        {a, b, c, d} = 4'b1001;
        @(negedge clock);
        ready = 1'b0;
        check_all("b2b_last", 4'b1101, 1'b1, 7'h3D);

        // Asynchronous reset between clock edges.
        capture(4'b1111);
        check_all("cap_1111", 4'b1000, 1'b1, 7'h7F);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_reset", 4'b0000, 1'b0, 7'h7E);
        check("async_reset_valid_al", {31'd0, l_valid}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
